// File: rtl/onchip_memory_stream_reader.sv
// Avalon-MM read master that streams a programmed run of words from the
// on-chip memory out of an Avalon-ST source with SOP/EOP framing.
// Reads are credit-limited so that every word in flight already has a
// FIFO slot reserved, which lets the memory run with no waitrequest.
module onchip_memory_stream_reader #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_WORDS    = 3125,
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_address,
  input  logic [ADDR_WIDTH-1:0] word_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [3:0]            mem_byteenable,
  output logic                  mem_clken,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  output logic [DATA_WIDTH-1:0] st_data,
  output logic                  st_valid,
  input  logic                  st_ready,
  output logic                  st_startofpacket,
  output logic                  st_endofpacket
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_WORDS - 1);
  localparam logic [LVL_W:0]        CREDITS   = (LVL_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [ADDR_WIDTH-1:0] count_reg, count_next;
  logic [ADDR_WIDTH-1:0] issued_reg, issued_next;

  // One tag per outstanding read; the oldest stage lines up with mem_readdata.
  logic [READ_LATENCY-1:0] tag_valid_reg;
  logic [READ_LATENCY-1:0] tag_first_reg;
  logic [READ_LATENCY-1:0] tag_last_reg;
  logic [LVL_W-1:0]        inflight_reg;

  // Output FIFO: {sop, eop, data} per entry, pointers carry one wrap bit.
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [LVL_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]   level;
  logic [ENTRY_W-1:0] head;

  logic credit_ok;
  logic issue;
  logic issue_first;
  logic issue_last;
  logic push;
  logic pop;

  assign level     = wr_ptr_reg - rd_ptr_reg;
  assign credit_ok = ({1'b0, level} + {1'b0, inflight_reg}) < CREDITS;
  assign issue     = (state_reg == READ) && (issued_reg < count_reg) && credit_ok;
  assign issue_first = (issued_reg == '0);
  assign issue_last  = (issued_reg == (count_reg - 1'b1));
  assign push      = tag_valid_reg[READ_LATENCY-1];
  assign pop       = st_valid && st_ready;

  assign head             = fifo_mem[rd_ptr_reg[PTR_W-1:0]];
  assign st_valid         = (level != '0);
  assign st_data          = st_valid ? head[DATA_WIDTH-1:0] : '0;
  assign st_startofpacket = st_valid && head[DATA_WIDTH+1];
  assign st_endofpacket   = st_valid && head[DATA_WIDTH];

  assign busy           = (state_reg != IDLE);
  assign done           = (state_reg == DONE);
  assign mem_chipselect = issue;
  assign mem_address    = issue ? addr_reg : '0;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;

  // Command state, read address and issue counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      count_reg  <= '0;
      issued_reg <= '0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      count_reg  <= count_next;
      issued_reg <= issued_next;
    end
  end

  // Next-state logic: latch the command, walk the address with wrap, drain.
  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    count_next  = count_reg;
    issued_next = issued_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            addr_next   = base_address;
            count_next  = word_count;
            issued_next = '0;
            state_next  = READ;
          end else begin
            state_next = DONE;
          end
        end
      end
      READ: begin
        if (issue) begin
          addr_next   = (addr_reg == LAST_ADDR) ? '0 : addr_reg + 1'b1;
          issued_next = issued_reg + 1'b1;
          if (issue_last) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Leave once nothing is in flight and the final beat goes out now or already went.
        if ((inflight_reg == '0) &&
            ((level == '0) || ((level == LVL_W'(1)) && pop))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Tag pipeline tracking each issued read until its data returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid_reg <= '0;
      tag_first_reg <= '0;
      tag_last_reg  <= '0;
      inflight_reg  <= '0;
    end else begin
      tag_valid_reg[0] <= issue;
      tag_first_reg[0] <= issue && issue_first;
      tag_last_reg[0]  <= issue && issue_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_valid_reg[i] <= tag_valid_reg[i-1];
        tag_first_reg[i] <= tag_first_reg[i-1];
        tag_last_reg[i]  <= tag_last_reg[i-1];
      end
      inflight_reg <= inflight_reg + LVL_W'(issue) - LVL_W'(push);
    end
  end

  // FIFO storage: returning words are captured with their framing flags.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[PTR_W-1:0]] <=
        {tag_first_reg[READ_LATENCY-1], tag_last_reg[READ_LATENCY-1], mem_readdata};
    end
  end

  // FIFO pointers; simultaneous push and pop keep the level unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

endmodule
